// File: rtl/mem_pkg.sv
// Shared definitions for the mem_copier DMA block.
//   copier_state_t : FSM encoding (IDLE, READ, WRITE, FIN)
//   WORD_BYTES     : byte stride between consecutive 32-bit words
//   ALIGN_MASK     : low address bits that must be zero for word alignment
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } copier_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mmap_dev.sv
// Memory-mapped word bus shared between masters and RAM/ROM slaves.
//   addr : byte address (slaves use addr[31:2])
//   re   : read strobe; the slave updates rd on the following negedge
//   we   : write strobe; the write commits at the posedge ending the cycle
//   wd   : write data
//   rd   : read data from the slave
interface mmap_dev;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output addr, output re, output we, output wd, input rd);
  modport slave  (input addr, input re, input we, input wd, output rd);
endinterface

// File: rtl/mem_copier_copy_buffer.sv
// copy_buffer: BURST x 32-bit register array holding one read burst until
// it is written back out.
//   clk     : system clock
//   wr_en   : store wr_data at wr_idx on the rising edge
//   wr_idx  : write slot
//   wr_data : word to store
//   rd_idx  : read slot
//   rd_data : word at rd_idx (combinational read of registered contents)
// Contents are not reset; every slot is written before it is read.
module copy_buffer #(
  parameter int BURST = 4,
  parameter int IDX_W = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] slot_r [BURST];

  // Capture one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = slot_r[rd_idx];

endmodule

// File: rtl/mem_copier.sv
// mem_copier: bus-master DMA that copies len 32-bit words from src_addr to
// dst_addr in read-buffer-write bursts of up to BURST words.
//   clk, rst  : clock and synchronous active-high reset
//   start     : one-cycle request, only honoured in IDLE
//   src_addr  : word-aligned source byte address
//   dst_addr  : word-aligned destination byte address
//   len       : number of words to copy
//   busy      : high while reading or writing
//   done      : one-cycle completion pulse
//   err       : sticky misalignment flag, cleared by the next accepted start
//   iface     : mmap_dev master port
// All bus outputs are decoded from registers only; rd feeds just the buffer.
module mem_copier
  import mem_pkg::*;
#(
  parameter int BURST = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  mmap_dev.master          iface
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;

  copier_state_t    state_r;
  copier_state_t    state_next_s;
  logic [31:0]      src_ptr_r;
  logic [31:0]      dst_ptr_r;
  logic [LEN_W-1:0] remaining_r;
  logic [CNT_W-1:0] chunk_r;
  logic [CNT_W-1:0] idx_r;
  logic             err_r;

  logic             misaligned_s;
  logic             last_beat_s;
  logic [LEN_W-1:0] rem_dec_s;
  logic [31:0]      buf_rd_s;

  logic             re_s;
  logic             we_s;
  logic [31:0]      addr_s;
  logic [31:0]      wd_s;
  logic             busy_s;
  logic             done_s;

  // Size of the next burst: BURST words, or whatever is left if fewer.
  function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] words);
    if (words >= LEN_W'(BURST)) begin
      chunk_of = CNT_W'(BURST);
    end else begin
      chunk_of = CNT_W'(words);
    end
  endfunction

  assign misaligned_s = ((src_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                        ((dst_addr[1:0] & ALIGN_MASK) != 2'b00);
  assign last_beat_s  = (idx_r == (chunk_r - CNT_W'(1)));
  assign rem_dec_s    = remaining_r - LEN_W'(1);

  copy_buffer #(
    .BURST (BURST),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (state_r == READ),
    .wr_idx  (idx_r[IDX_W-1:0]),
    .wr_data (iface.rd),
    .rd_idx  (idx_r[IDX_W-1:0]),
    .rd_data (buf_rd_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (misaligned_s || (len == LEN_W'(0))) begin
            state_next_s = FIN;
          end else begin
            state_next_s = READ;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (last_beat_s) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = READ;
        end
      end
      WRITE: begin
        if (last_beat_s) begin
          if (rem_dec_s == LEN_W'(0)) begin
            state_next_s = FIN;
          end else begin
            state_next_s = READ;
          end
        end else begin
          state_next_s = WRITE;
        end
      end
      FIN:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Pointers, counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr_r   <= 32'h0000_0000;
      dst_ptr_r   <= 32'h0000_0000;
      remaining_r <= LEN_W'(0);
      chunk_r     <= CNT_W'(0);
      idx_r       <= CNT_W'(0);
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            src_ptr_r   <= src_addr;
            dst_ptr_r   <= dst_addr;
            remaining_r <= len;
            chunk_r     <= chunk_of(len);
            idx_r       <= CNT_W'(0);
            err_r       <= misaligned_s;
          end
        end
        READ: begin
          src_ptr_r <= src_ptr_r + 32'(WORD_BYTES);
          idx_r     <= last_beat_s ? CNT_W'(0) : (idx_r + CNT_W'(1));
        end
        WRITE: begin
          dst_ptr_r   <= dst_ptr_r + 32'(WORD_BYTES);
          remaining_r <= rem_dec_s;
          if (last_beat_s) begin
            idx_r   <= CNT_W'(0);
            chunk_r <= chunk_of(rem_dec_s);
          end else begin
            idx_r <= idx_r + CNT_W'(1);
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Output decode from registered state.
  always_comb begin
    re_s   = 1'b0;
    we_s   = 1'b0;
    addr_s = 32'h0000_0000;
    wd_s   = 32'h0000_0000;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      READ: begin
        re_s   = 1'b1;
        addr_s = src_ptr_r;
        busy_s = 1'b1;
      end
      WRITE: begin
        we_s   = 1'b1;
        addr_s = dst_ptr_r;
        wd_s   = buf_rd_s;
        busy_s = 1'b1;
      end
      FIN: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign iface.re   = re_s;
  assign iface.we   = we_s;
  assign iface.addr = addr_s;
  assign iface.wd   = wd_s;
  assign busy       = busy_s;
  assign done       = done_s;
  assign err        = err_r;

endmodule

// File: tb/tb_mem_copier.sv
module tb_mem_copier;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;

  mmap_dev bus ();

  mem_copier #(.BURST(4), .LEN_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iface    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slave memory, word-indexed.
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] rdmem(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    else return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and act as the slave for the cycle now on the bus.
  task automatic step();
    @(negedge clk);
    if (bus.we === 1'b1) mem[bus.addr[31:2]] = bus.wd;
    if (bus.re === 1'b1) bus.rd = rdmem(bus.addr[31:2]);
  endtask

  task automatic chk_quiet(input string tag, input logic exp_err);
    chk({tag, " re"},   {31'd0, bus.re}, 32'd0);
    chk({tag, " we"},   {31'd0, bus.we}, 32'd0);
    chk({tag, " addr"}, bus.addr, 32'd0);
    chk({tag, " wd"},   bus.wd, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " err"},  {31'd0, err}, {31'd0, exp_err});
  endtask

  // Start a copy and check every cycle against a chunked sequential copy model.
  task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int n, input logic exp_err, input int poke_at);
    bit          q_re [$];
    logic [31:0] q_addr [$];
    logic [31:0] q_wd [$];
    logic [31:0] s, d;
    logic [31:0] bufm [4];
    int rem, ch;
    s = src; d = dst; rem = n;
    if (!exp_err) begin
      while (rem > 0) begin
        ch = (rem > 4) ? 4 : rem;
        for (int i = 0; i < ch; i++) begin
          bufm[i] = rdmem(s[31:2]);
          q_re.push_back(1'b1); q_addr.push_back(s); q_wd.push_back(32'd0);
          s = s + 32'd4;
        end
        for (int i = 0; i < ch; i++) begin
          q_re.push_back(1'b0); q_addr.push_back(d); q_wd.push_back(bufm[i]);
          d = d + 32'd4;
        end
        rem -= ch;
      end
    end
    src_addr = src; dst_addr = dst; len = 16'(n); start = 1'b1;
    for (int c = 1; c <= q_re.size(); c++) begin
      step();
      if (c == 1) start = 1'b0;
      chk($sformatf("%s c%0d re", tag, c),   {31'd0, bus.re}, {31'd0, q_re[c-1]});
      chk($sformatf("%s c%0d we", tag, c),   {31'd0, bus.we}, {31'd0, !q_re[c-1]});
      chk($sformatf("%s c%0d addr", tag, c), bus.addr, q_addr[c-1]);
      chk($sformatf("%s c%0d wd", tag, c),   bus.wd, q_wd[c-1]);
      chk($sformatf("%s c%0d busy", tag, c), {31'd0, busy}, 32'd1);
      chk($sformatf("%s c%0d done", tag, c), {31'd0, done}, 32'd0);
      if (c == poke_at) begin
        src_addr = 32'h0000_0300; dst_addr = 32'h0000_0304; len = 16'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    step();
    start = 1'b0;
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk_quiet({tag, " fin"}, exp_err);
    // A start in the FIN cycle must be ignored.
    src_addr = 32'h0000_0100; dst_addr = 32'h0000_0F00; len = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " post done"}, {31'd0, done}, 32'd0);
    chk_quiet({tag, " post"}, exp_err);
    step();
    chk_quiet({tag, " post2"}, exp_err);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = 16'd0;
    bus.rd = 32'd0;
    step(); step();
    chk({"reset", " done"}, {31'd0, done}, 32'd0);
    chk_quiet("reset", 1'b0);
    rst = 1'b0;
    step();

    // Basic copy.
    mem[30'h040] = 32'h11; mem[30'h041] = 32'h22; mem[30'h042] = 32'h33; mem[30'h043] = 32'h44;
    run_copy("basic", 32'h100, 32'h200, 4, 1'b0, 0);
    chk("basic dst0", rdmem(30'h080), 32'h11);
    chk("basic dst1", rdmem(30'h081), 32'h22);
    chk("basic dst2", rdmem(30'h082), 32'h33);
    chk("basic dst3", rdmem(30'h083), 32'h44);

    // Multi-burst.
    for (int i = 0; i < 6; i++) mem[30'h180 + 30'(i)] = 32'hA0 + 32'(i);
    run_copy("multi", 32'h600, 32'h700, 6, 1'b0, 0);
    chk("multi dst0", rdmem(30'h1C0), 32'hA0);
    chk("multi dst3", rdmem(30'h1C3), 32'hA3);
    chk("multi dst4", rdmem(30'h1C4), 32'hA4);
    chk("multi dst5", rdmem(30'h1C5), 32'hA5);

    // Zero length.
    run_copy("zero", 32'h100, 32'h800, 0, 1'b0, 0);
    chk("zero dst", {31'd0, mem.exists(30'h200)}, 32'd0);

    // Misaligned, then an aligned start clears err.
    run_copy("misal", 32'h102, 32'h900, 2, 1'b1, 0);
    chk("misal dst", {31'd0, mem.exists(30'h240)}, 32'd0);
    run_copy("realign", 32'h100, 32'h900, 1, 1'b0, 0);
    chk("realign dst", rdmem(30'h240), 32'h11);

    // Reset during the 3rd read.
    src_addr = 32'h100; dst_addr = 32'h500; len = 16'd4; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("rstmid read3 re", {31'd0, bus.re}, 32'd1);
    chk("rstmid read3 addr", bus.addr, 32'h108);
    rst = 1'b1;
    step();
    chk("rstmid done", {31'd0, done}, 32'd0);
    chk_quiet("rstmid", 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("rstmid dst%0d", i), {31'd0, mem.exists(30'h140 + 30'(i))}, 32'd0);

    // Address wrap with an ignored start mid-copy.
    mem[30'h3FFF_FFFE] = 32'hC0; mem[30'h3FFF_FFFF] = 32'hC1; mem[30'h0] = 32'hC2;
    run_copy("wrap", 32'hFFFF_FFF8, 32'hA00, 3, 1'b0, 2);
    chk("wrap dst0", rdmem(30'h280), 32'hC0);
    chk("wrap dst1", rdmem(30'h281), 32'hC1);
    chk("wrap dst2", rdmem(30'h282), 32'hC2);
    chk("wrap poke", {31'd0, mem.exists(30'h0C1)}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
